// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Purpose: walks the program counter and fetches one instruction per request
// from the control stage. Each request issues a single read strobe to
// instruction memory, waits a bounded number of cycles for the response, and
// presents the captured instruction together with its PC. Fetching stops for
// good on a program finish, an illegal-instruction marker, a misaligned
// target or a memory timeout; only reset restarts it.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_inst_next     one-cycle fetch request
//   i_branch_taken  previous instruction branched (sampled with i_inst_next)
//   i_imm           sign-extended branch offset (sampled with i_inst_next)
//   i_finish        program finished, stop fetching
//   o_i_addr        instruction-memory address (current PC)
//   o_i_valid_addr  one-cycle read strobe
//   i_i_inst        instruction-memory read data
//   i_i_valid_inst  read data valid, one cycle
//   o_inst          last captured instruction
//   o_valid_inst    one-cycle pulse, o_inst newly valid
//   o_pc            PC of o_inst
//   o_fetch_err     sticky timeout / misalignment error
//   o_inst_cnt      saturating count of captured instructions

module inst_fetch_unit #(
    parameter int ADDR_W  = 64,
    parameter int INST_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_next,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_imm,
    input  logic              i_finish,
    output logic [ADDR_W-1:0] o_i_addr,
    output logic              o_i_valid_addr,
    input  logic [INST_W-1:0] i_i_inst,
    input  logic              i_i_valid_inst,
    output logic [INST_W-1:0] o_inst,
    output logic              o_valid_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fetch_err,
    output logic [31:0]       o_inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              valid_addr_q, valid_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_inst_q, valid_inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              err_q, err_d;
    logic [31:0]       inst_cnt_q, inst_cnt_d;
    logic [ADDR_W-1:0] next_pc;

    // The very first fetch after reset targets address 0 as-is; afterwards
    // the PC advances sequentially or by the branch offset, wrapping freely.
    assign next_pc = first_q ? '0
                   : (i_branch_taken ? pc_q + i_imm : pc_q + ADDR_W'(4));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        first_d      = first_q;
        wait_cnt_d   = wait_cnt_q;
        valid_addr_d = 1'b0;
        inst_d       = inst_q;
        valid_inst_d = 1'b0;
        inst_pc_d    = inst_pc_q;
        err_d        = err_q;
        inst_cnt_d   = inst_cnt_q;

        // Finish takes priority over anything else happening in the same cycle.
        if (i_finish) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (i_inst_next) begin
                        // A misaligned target is fatal: keep the old PC and never strobe.
                        if (next_pc[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pc_d         = next_pc;
                            first_d      = 1'b0;
                            valid_addr_d = 1'b1;
                            state_d      = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    // A response on the last allowed cycle still wins over the timeout.
                    if (i_i_valid_inst) begin
                        inst_d       = i_i_inst;
                        inst_pc_d    = pc_q;
                        valid_inst_d = 1'b1;
                        if (inst_cnt_q != 32'hFFFF_FFFF) begin
                            inst_cnt_d = inst_cnt_q + 32'd1;
                        end
                        // An all-ones opcode field marks the end of the usable program.
                        state_d = (i_i_inst[6:0] == 7'h7F) ? S_DONE : S_HOLD;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            first_q      <= 1'b1;
            wait_cnt_q   <= '0;
            valid_addr_q <= 1'b0;
            inst_q       <= '0;
            valid_inst_q <= 1'b0;
            inst_pc_q    <= '0;
            err_q        <= 1'b0;
            inst_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            first_q      <= first_d;
            wait_cnt_q   <= wait_cnt_d;
            valid_addr_q <= valid_addr_d;
            inst_q       <= inst_d;
            valid_inst_q <= valid_inst_d;
            inst_pc_q    <= inst_pc_d;
            err_q        <= err_d;
            inst_cnt_q   <= inst_cnt_d;
        end
    end

    assign o_i_addr       = pc_q;
    assign o_i_valid_addr = valid_addr_q;
    assign o_inst         = inst_q;
    assign o_valid_inst   = valid_inst_q;
    assign o_pc           = inst_pc_q;
    assign o_fetch_err    = err_q;
    assign o_inst_cnt     = inst_cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
// Purpose: self-checking bench for inst_fetch_unit. Expected read strobes and
// captured instructions are queued by the stimulus side from a simple PC
// model; a monitor pops and compares whenever the DUT strobes or pulses, and
// reports any strobe or pulse that nothing expected.

module tb_inst_fetch_unit;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [31:0] cnt;
    } exp_inst_t;

    logic        clk;
    logic        rstN;
    logic        iInstNext;
    logic        iBranchTaken;
    logic [63:0] iImm;
    logic        iFinish;
    logic [63:0] oIAddr;
    logic        oIValidAddr;
    logic [31:0] iIInst;
    logic        iIValidInst;
    logic [31:0] oInst;
    logic        oValidInst;
    logic [63:0] oPc;
    logic        oFetchErr;
    logic [31:0] oInstCnt;

    logic [63:0] expAddrQ[$];
    exp_inst_t   expInstQ[$];
    exp_inst_t   expInst;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: PC of the last issued fetch, first-fetch flag, count.
    logic [63:0] mPc;
    bit          mFirst;
    logic [31:0] mCnt;

    inst_fetch_unit #(.ADDR_W(64), .INST_W(32), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_inst_next    (iInstNext),
        .i_branch_taken (iBranchTaken),
        .i_imm          (iImm),
        .i_finish       (iFinish),
        .o_i_addr       (oIAddr),
        .o_i_valid_addr (oIValidAddr),
        .i_i_inst       (iIInst),
        .i_i_valid_inst (iIValidInst),
        .o_inst         (oInst),
        .o_valid_inst   (oValidInst),
        .o_pc           (oPc),
        .o_fetch_err    (oFetchErr),
        .o_inst_cnt     (oInstCnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and every instruction pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rstN) begin
            if (oIValidAddr) begin
                if (expAddrQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_strobe: got addr 0x%0h, expected no strobe", oIAddr);
                end else begin
                    checkOutput("strobe_addr", oIAddr, expAddrQ.pop_front());
                end
            end
            if (oValidInst) begin
                if (expInstQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_inst: got inst 0x%0h, expected no pulse", oInst);
                end else begin
                    expInst = expInstQ.pop_front();
                    checkOutput("inst_data", {32'd0, oInst}, {32'd0, expInst.inst});
                    checkOutput("inst_pc", oPc, expInst.pc);
                    checkOutput("inst_cnt", {32'd0, oInstCnt}, {32'd0, expInst.cnt});
                end
            end
        end
    end

    // Issue one fetch; optionally answer it after 'delay' cycles in WAIT.
    task automatic applyStimulus(input bit taken, input logic [63:0] imm,
                                 input logic [31:0] inst, input int delay, input bit respond);
        logic [63:0] addr;
        @(negedge clk);
        addr = mFirst ? 64'd0 : mPc + (taken ? imm : 64'd4);
        iInstNext    = 1'b1;
        iBranchTaken = taken;
        iImm         = imm;
        expAddrQ.push_back(addr);
        mPc    = addr;
        mFirst = 1'b0;
        @(negedge clk);
        iInstNext    = 1'b0;
        iBranchTaken = 1'b0;
        iImm         = '0;
        if (respond) begin
            repeat (delay + 1) @(negedge clk);
            iIValidInst = 1'b1;
            iIInst      = inst;
            if (mCnt != 32'hFFFF_FFFF) mCnt++;
            expInstQ.push_back('{inst: inst, pc: addr, cnt: mCnt});
            @(negedge clk);
            iIValidInst = 1'b0;
            iIInst      = '0;
            @(negedge clk);
        end
    endtask

    // Raw fetch request that the DUT should refuse (no expectation queued).
    task automatic applyRawRequest(input bit taken, input logic [63:0] imm, input bit finish);
        @(negedge clk);
        iInstNext    = 1'b1;
        iBranchTaken = taken;
        iImm         = imm;
        iFinish      = finish;
        @(negedge clk);
        iInstNext    = 1'b0;
        iBranchTaken = 1'b0;
        iImm         = '0;
        iFinish      = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Wait (bounded) for all expectations to be consumed.
    task automatic checkDrained(input string name);
        int guard = 0;
        while ((expAddrQ.size() != 0 || expInstQ.size() != 0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(name, 64'(expAddrQ.size() + expInstQ.size()), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"}, oIAddr, 64'd0);
        checkOutput({tag, "_strobe"}, {63'd0, oIValidAddr}, 64'd0);
        checkOutput({tag, "_inst"}, {32'd0, oInst}, 64'd0);
        checkOutput({tag, "_valid"}, {63'd0, oValidInst}, 64'd0);
        checkOutput({tag, "_pc"}, oPc, 64'd0);
        checkOutput({tag, "_err"}, {63'd0, oFetchErr}, 64'd0);
        checkOutput({tag, "_cnt"}, {32'd0, oInstCnt}, 64'd0);
    endtask

    // Reset in the middle of a cycle, check reset values, release.
    task automatic applyReset(input string tag);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkResetValues(tag);
        @(negedge clk);
        rstN   = 1'b1;
        mPc    = '0;
        mFirst = 1'b1;
        mCnt   = '0;
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rInst;
        logic [63:0] rImm;
        logic [63:0] heldAddr;
        rstN = 1'b0; iInstNext = 1'b0; iBranchTaken = 1'b0; iImm = '0;
        iFinish = 1'b0; iIInst = '0; iIValidInst = 1'b0;
        mPc = '0; mFirst = 1'b1; mCnt = '0;
        repeat (2) @(negedge clk);
        checkResetValues("por");
        rstN = 1'b1;

        // First fetch at 0, sequential step, then a backward branch that wraps.
        applyStimulus(1'b0, 64'd0, 32'h0000_0013, 2, 1'b1);
        applyStimulus(1'b0, 64'd0, 32'h0000_0093, 0, 1'b1);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 32'h0000_0113, 5, 1'b1);
        checkOutput("wrap_addr", oIAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        checkDrained("drain_directed");

        // Randomized aligned branches and response delays.
        for (int i = 0; i < 30; i++) begin
            rInst = $urandom;
            if (rInst[6:0] == 7'h7F) rInst[0] = 1'b0;
            rImm = {$urandom, $urandom} & ~64'd3;
            applyStimulus(1'($urandom_range(0, 1)), rImm, rInst, $urandom_range(0, TIMEOUT - 2), 1'b1);
        end
        checkDrained("drain_random");
        checkOutput("inst_hold", {32'd0, oInst}, {32'd0, rInst});

        // Misaligned branch target from PC 4: error, no strobe, PC kept, then dead.
        applyReset("rst_a");
        applyStimulus(1'b0, 64'd0, 32'h0000_0013, 1, 1'b1);
        applyStimulus(1'b0, 64'd0, 32'h0000_0013, 1, 1'b1);
        applyRawRequest(1'b1, 64'd6, 1'b0);
        checkOutput("misalign_err", {63'd0, oFetchErr}, 64'd1);
        checkOutput("misalign_addr", oIAddr, 64'd4);
        applyRawRequest(1'b0, 64'd0, 1'b0);
        checkOutput("misalign_err_sticky", {63'd0, oFetchErr}, 64'd1);
        checkDrained("drain_misalign");

        // Memory never answers: error exactly TIMEOUT cycles after WAIT entry.
        applyReset("rst_b");
        applyStimulus(1'b0, 64'd0, 32'd0, 0, 1'b0);
        @(posedge clk);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_early", {63'd0, oFetchErr}, 64'd0);
        @(negedge clk);
        checkOutput("timeout_err", {63'd0, oFetchErr}, 64'd1);
        iIValidInst = 1'b1; iIInst = 32'h0000_0013;
        @(negedge clk);
        iIValidInst = 1'b0; iIInst = '0;
        repeat (2) @(negedge clk);
        checkOutput("timeout_cnt", {32'd0, oInstCnt}, 64'd0);

        // Illegal-marker instruction: pulse still seen, then no further fetching.
        applyReset("rst_c");
        applyStimulus(1'b0, 64'd0, 32'h0000_007F, 3, 1'b1);
        applyRawRequest(1'b0, 64'd0, 1'b0);
        checkOutput("marker_inst_hold", {32'd0, oInst}, 64'h7F);
        checkDrained("drain_marker");

        // Finish in the same cycle as a request wins and blocks later requests.
        applyReset("rst_d");
        applyStimulus(1'b0, 64'd0, 32'h0000_0013, 0, 1'b1);
        applyRawRequest(1'b0, 64'd0, 1'b1);
        applyRawRequest(1'b0, 64'd0, 1'b0);
        checkOutput("finish_addr", oIAddr, 64'd0);
        checkOutput("finish_err", {63'd0, oFetchErr}, 64'd0);
        checkDrained("drain_finish");

        // Reset mid-WAIT; a stale response in IDLE is ignored; fetching restarts at 0.
        applyReset("rst_e");
        applyStimulus(1'b0, 64'd0, 32'h0000_0013, 0, 1'b1);
        applyStimulus(1'b0, 64'd0, 32'd0, 0, 1'b0);
        heldAddr = oIAddr;
        checkOutput("pre_reset_addr", heldAddr, 64'd4);
        applyReset("rst_mid_wait");
        iIValidInst = 1'b1; iIInst = 32'h0000_0093;
        @(negedge clk);
        iIValidInst = 1'b0; iIInst = '0;
        @(negedge clk);
        checkOutput("stale_inst", {32'd0, oInst}, 64'd0);
        applyStimulus(1'b0, 64'd0, 32'h0000_0033, 4, 1'b1);
        checkDrained("drain_restart");
        checkOutput("restart_cnt", {32'd0, oInstCnt}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
